// File: rtl/display_if.sv
// Host-side bundle for the 7-segment display driver.
// Value/strobe inputs and scanned anode/segment outputs.
interface display_if;
  logic [15:0] number;
  logic        load;
  logic        dec_mode;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  modport master (
    output number, load, dec_mode, blank_lz,
    input  an, seg, dp, busy
  );

  modport slave (
    input  number, load, dec_mode, blank_lz,
    output an, seg, dp, busy
  );
endinterface

// File: rtl/display_driver_7seg.sv
// Multiplexed 8-digit 7-segment driver.
// Hex load is immediate; decimal runs a 16-cycle double dabble.
module display_driver_7seg #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic     clk,
  input  logic     rst,
  display_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic [15:0]     cap;
  logic [19:0]     bcd;
  logic [19:0]     bcd_nx;
  logic [4:0]      iter;
  logic [3:0]      dig [8];
  logic [2:0]      used;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [2:0]      msd;
  logic [3:0]      cur;
  logic            lit;

  function automatic logic [19:0] dabble(
    input logic [19:0] b,
    input logic        bit_in
  );
    logic [19:0] a;
    for (int k = 0; k < 5; k++) begin
      if (b[4*k +: 4] >= 4'd5)
        a[4*k +: 4] = b[4*k +: 4] + 4'd3;
      else
        a[4*k +: 4] = b[4*k +: 4];
    end
    return {a[18:0], bit_in};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    unique case (d)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign bcd_nx   = dabble(bcd, cap[15]);
  assign bus.busy = (state == CONV);

  // Load/convert FSM owning the displayed digit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cap   <= '0;
      bcd   <= '0;
      iter  <= '0;
      used  <= 3'd4;
      for (int i = 0; i < 8; i++) dig[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            if (!bus.dec_mode) begin
              for (int i = 0; i < 4; i++)
                dig[i] <= bus.number[4*i +: 4];
              for (int i = 4; i < 8; i++)
                dig[i] <= '0;
              used <= 3'd4;
            end else begin
              cap   <= bus.number;
              bcd   <= '0;
              iter  <= '0;
              state <= CONV;
            end
          end
        end
        CONV: begin
          bcd  <= bcd_nx;
          cap  <= {cap[14:0], 1'b0};
          iter <= iter + 5'd1;
          if (iter == 5'd15) begin
            for (int i = 0; i < 5; i++)
              dig[i] <= bcd_nx[4*i +: 4];
            for (int i = 5; i < 8; i++)
              dig[i] <= '0;
            used  <= 3'd5;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Refresh divider and scan index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Highest nonzero digit; 0 when all digits are zero.
  always_comb begin
    msd = '0;
    for (int i = 1; i < 8; i++)
      if (dig[i] != 4'h0) msd = 3'(i);
  end

  assign cur = dig[idx];
  assign lit = (idx < used) &&
               !(bus.blank_lz && (idx > msd));

  // Registered anode/segment drive for the scanned digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.an  <= 8'hFF;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else begin
      bus.dp <= 1'b1;
      if (lit) begin
        bus.an  <= ~(8'h01 << idx);
        bus.seg <= glyph(cur);
      end else begin
        bus.an  <= 8'hFF;
        bus.seg <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_display_driver_7seg.sv
// Bench for display_driver_7seg with a 4-cycle refresh.
// Vector table feeds a scoreboard of per-digit glyphs.
module tb_display_driver_7seg;

  logic clk = 1'b0;
  logic rst = 1'b0;

  display_if bus();

  display_driver_7seg #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     number;
    logic            dec;
    logic            blz;
    logic            inject;
    int              exp_busy;
    logic [7:0][6:0] segs;
  } vec_t;

  vec_t tbl [11];
  vec_t sb [$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(
    input logic [15:0] n,
    input logic d,
    input logic b,
    input logic inj,
    input int eb,
    input logic [55:0] s
  );
    vec_t v;
    v.number   = n;
    v.dec      = d;
    v.blz      = b;
    v.inject   = inj;
    v.exp_busy = eb;
    v.segs     = s;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic observe(input string tag);
    logic [6:0] seen [8];
    logic       multi;
    logic       dpbad;
    int         zeros;
    vec_t       e;
    for (int i = 0; i < 8; i++) seen[i] = 7'h7F;
    multi = 1'b0;
    dpbad = 1'b0;
    repeat (2) @(negedge clk);
    repeat (40) begin
      @(negedge clk);
      zeros = 0;
      for (int i = 0; i < 8; i++)
        if (!bus.an[i]) begin
          zeros++;
          seen[i] = bus.seg;
        end
      if (zeros > 1) multi = 1'b1;
      if (bus.dp !== 1'b1) dpbad = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, "_an_onehot"}, 32'(multi), 32'd0);
    chk({tag, "_dp"}, 32'(dpbad), 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_digit%0d", tag, i),
          32'(seen[i]), 32'(e.segs[i]));
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int nb;
    int guard;
    sb.push_back(v);
    @(negedge clk);
    bus.number   = v.number;
    bus.dec_mode = v.dec;
    bus.blank_lz = v.blz;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    nb    = 0;
    guard = 0;
    while (bus.busy && guard < 100) begin
      nb++;
      if (v.inject && nb == 3) begin
        bus.number = 16'd999;
        bus.load   = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.load = 1'b0;
    chk($sformatf("v%0d_busy_cycles", n),
        32'(nb), 32'(v.exp_busy));
    observe($sformatf("v%0d", n));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_an"}, 32'(bus.an), 32'hFF);
    chk({tag, "_seg"}, 32'(bus.seg), 32'h7F);
    chk({tag, "_dp"}, 32'(bus.dp), 32'h1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  vec_t rv;

  initial begin
    tbl[0]  = mk(16'hBEEF, 0, 0, 0, 0,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F,
       7'h03, 7'h06, 7'h06, 7'h0E});
    tbl[1]  = mk(16'd12345, 1, 0, 0, 16,
      {7'h7F, 7'h7F, 7'h7F, 7'h79,
       7'h24, 7'h30, 7'h19, 7'h12});
    tbl[2]  = mk(16'd65535, 1, 0, 0, 16,
      {7'h7F, 7'h7F, 7'h7F, 7'h02,
       7'h12, 7'h12, 7'h30, 7'h12});
    tbl[3]  = mk(16'd0, 1, 0, 0, 16,
      {7'h7F, 7'h7F, 7'h7F, 7'h40,
       7'h40, 7'h40, 7'h40, 7'h40});
    tbl[4]  = mk(16'd0, 1, 1, 0, 16,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F,
       7'h7F, 7'h7F, 7'h7F, 7'h40});
    tbl[5]  = mk(16'h0042, 0, 1, 0, 0,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F,
       7'h7F, 7'h7F, 7'h19, 7'h24});
    tbl[6]  = mk(16'h0042, 0, 0, 0, 0,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F,
       7'h40, 7'h40, 7'h19, 7'h24});
    tbl[7]  = mk(16'h00A0, 0, 1, 0, 0,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F,
       7'h7F, 7'h7F, 7'h08, 7'h40});
    tbl[8]  = mk(16'd12345, 1, 0, 1, 16,
      {7'h7F, 7'h7F, 7'h7F, 7'h79,
       7'h24, 7'h30, 7'h19, 7'h12});
    tbl[9]  = mk(16'd42, 1, 1, 0, 16,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F,
       7'h7F, 7'h7F, 7'h19, 7'h24});
    tbl[10] = mk(16'h1000, 0, 1, 0, 0,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F,
       7'h79, 7'h40, 7'h40, 7'h40});

    bus.number   = '0;
    bus.load     = 1'b0;
    bus.dec_mode = 1'b0;
    bus.blank_lz = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_outs("por");
    rst = 1'b1;
    rv = mk(16'd0, 0, 0, 0, 0,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F,
       7'h40, 7'h40, 7'h40, 7'h40});
    sb.push_back(rv);
    observe("post_por");

    for (int n = 0; n < 11; n++)
      run_vec(tbl[n], n);

    @(negedge clk);
    bus.number   = 16'd12345;
    bus.dec_mode = 1'b1;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (7) @(negedge clk);
    chk("midconv_busy", 32'(bus.busy), 32'h1);
    #2 rst = 1'b0;
    #1 chk_reset_outs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rel_busy", 32'(bus.busy), 32'h0);
    sb.push_back(rv);
    observe("rst_rel");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
